// File: rtl/des_key_sched.sv
// Iterative DES/3DES round-key scheduler: PC-1 per key, one rotate+PC-2 per clock into a key table.
// Optional odd-parity key check enabled by DES_KEY_SCHED_PARITY_CHK_EN.
//   state | meaning
//   IDLE  | waiting for a key load, key_ready=1
//   PC1   | load C/D from PC-1 of key k
//   GEN   | rotate C/D, write PC-2 to table[k][r]
//   DONE  | raise keys_rdy, return to IDLE
module des_key_sched #(
  parameter int NUM_KEYS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [64*NUM_KEYS-1:0]  key_in,
  input  logic                    key_valid,
  output logic                    key_ready,
  output logic                    busy,
  output logic                    keys_rdy,
  input  logic                    rd_en,
  input  logic [1:0]              rd_key_sel,
  input  logic [3:0]              rd_round,
  input  logic                    rd_decrypt,
  output logic [47:0]             rd_data,
  output logic                    parity_err
);

  localparam int NE = 16 * NUM_KEYS;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PC1  = 2'd1;
  localparam logic [1:0] S_GEN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [1:0] LAST_K = 2'(NUM_KEYS - 1);
  localparam logic [2:0] NK     = 3'(NUM_KEYS);

  // FIPS bit numbers (1 = MSB) for each output position, MSB first
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [55:0] f_pc1(input logic [63:0] k);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1_T[i]];
    return o;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] cd);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_T[i]];
    return o;
  endfunction

  logic [1:0]             r_state;
  logic [1:0]             r_k;
  logic [3:0]             r_r;
  logic [27:0]            r_c, r_d;
  logic [64*NUM_KEYS-1:0] r_key;
  logic                   r_keys_rdy;
  logic [47:0]            r_table [NE];

  logic [63:0] w_key_cur;
  logic        w_two;
  logic [27:0] w_c_rot, w_d_rot;
  logic [47:0] w_subkey;
  logic [5:0]  w_wr_idx;
  logic [3:0]  w_rd_round;
  logic [47:0] w_rd_val;
  logic        w_rd_zero;

  assign key_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_PC1) || (r_state == S_GEN);
  assign keys_rdy  = r_keys_rdy;

  always_comb begin
    w_key_cur = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (r_k == 2'(i)) w_key_cur = r_key[64*i +: 64];
  end

  // Rounds 1, 2, 9 and 16 shift by one; all others by two
  assign w_two    = !((r_r == 4'd0) || (r_r == 4'd1) || (r_r == 4'd8) || (r_r == 4'd15));
  assign w_c_rot  = w_two ? {r_c[25:0], r_c[27:26]} : {r_c[26:0], r_c[27]};
  assign w_d_rot  = w_two ? {r_d[25:0], r_d[27:26]} : {r_d[26:0], r_d[27]};
  assign w_subkey = f_pc2({w_c_rot, w_d_rot});
  assign w_wr_idx = {r_k, r_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_r        <= '0;
      r_c        <= '0;
      r_d        <= '0;
      r_key      <= '0;
      r_keys_rdy <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (key_valid) begin
          r_key      <= key_in;
          r_keys_rdy <= 1'b0;
          r_k        <= '0;
          r_state    <= S_PC1;
        end
        S_PC1: begin
          {r_c, r_d} <= f_pc1(w_key_cur);
          r_r        <= '0;
          r_state    <= S_GEN;
        end
        S_GEN: begin
          r_c <= w_c_rot;
          r_d <= w_d_rot;
          r_r <= r_r + 4'd1;
          if (r_r == 4'd15) begin
            if (r_k != LAST_K) begin
              r_k     <= r_k + 2'd1;
              r_state <= S_PC1;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_keys_rdy <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) r_table[i] <= '0;
    end else if (r_state == S_GEN) begin
      for (int i = 0; i < NE; i++)
        if (w_wr_idx == 6'(i)) r_table[i] <= w_subkey;
    end
  end

  assign w_rd_round = rd_decrypt ? (4'd15 - rd_round) : rd_round;
  assign w_rd_zero  = busy || !r_keys_rdy || ({1'b0, rd_key_sel} >= NK);

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NE; i++)
      if ({rd_key_sel, w_rd_round} == 6'(i)) w_rd_val = r_table[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= w_rd_zero ? 48'd0 : w_rd_val;
  end

`ifdef DES_KEY_SCHED_PARITY_CHK_EN
  logic r_parity_err;
  logic w_par_bad;

  always_comb begin
    w_par_bad = 1'b0;
    for (int i = 0; i < 8*NUM_KEYS; i++)
      if (!(^key_in[8*i +: 8])) w_par_bad = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_parity_err <= 1'b0;
    else if ((r_state == S_IDLE) && key_valid) r_parity_err <= w_par_bad;
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched: one DES and one 3DES instance, read results scored from a queue.
module tb_des_key_sched;

  localparam logic [63:0] KEY_A = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] KEY_B = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [63:0]  key_in1;
  logic         key_valid1, key_ready1, busy1, keys_rdy1, parity_err1;
  logic [47:0]  rd_data1;
  logic [191:0] key_in3;
  logic         key_valid3, key_ready3, busy3, keys_rdy3, parity_err3;
  logic [47:0]  rd_data3;
  logic         rd_en, rd_decrypt;
  logic [1:0]   rd_key_sel;
  logic [3:0]   rd_round;

  logic [47:0] K [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  int n_checks = 0;
  int n_errors = 0;
  logic [47:0] sb_q [$];

  des_key_sched #(.NUM_KEYS(1)) u_des (
    .clk(clk), .rst_n(rst_n), .key_in(key_in1), .key_valid(key_valid1),
    .key_ready(key_ready1), .busy(busy1), .keys_rdy(keys_rdy1),
    .rd_en(rd_en), .rd_key_sel(rd_key_sel), .rd_round(rd_round), .rd_decrypt(rd_decrypt),
    .rd_data(rd_data1), .parity_err(parity_err1));

  des_key_sched #(.NUM_KEYS(3)) u_3des (
    .clk(clk), .rst_n(rst_n), .key_in(key_in3), .key_valid(key_valid3),
    .key_ready(key_ready3), .busy(busy3), .keys_rdy(keys_rdy3),
    .rd_en(rd_en), .rd_key_sel(rd_key_sel), .rd_round(rd_round), .rd_decrypt(rd_decrypt),
    .rd_data(rd_data3), .parity_err(parity_err3));

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input bit use3, input logic [1:0] sel,
                    input logic [3:0] rnd, input logic dec, input logic [47:0] exp);
    logic [47:0] e;
    @(negedge clk);
    rd_en = 1'b1; rd_key_sel = sel; rd_round = rnd; rd_decrypt = dec;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    chk(tag, use3 ? rd_data3 : rd_data1, e);
  endtask

  task automatic rd_off();
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic load1(input logic [63:0] k);
    @(negedge clk);
    key_in1 = k; key_valid1 = 1'b1;
    @(posedge clk); #1;
    key_valid1 = 1'b0;
    chk("busy_after_accept", 48'(busy1), 48'd1);
  endtask

  // Counts edges after the accept edge until keys_rdy; optionally pokes key_valid3 while busy
  task automatic wait_rdy(input string tag, input bit use3, input int exp_edges, input bit poke);
    int e;
    e = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (poke) begin
        key_valid3 = (i == 5) || (i == 25) || (i == 40);
        key_in3    = {3{64'hDEADBEEF00000000}};
      end
      if ((use3 ? keys_rdy3 : keys_rdy1) === 1'b1) begin
        e = i;
        break;
      end
    end
    chk(tag, 48'(e), 48'(exp_edges));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    key_in1 = '0; key_valid1 = 1'b0;
    key_in3 = '0; key_valid3 = 1'b0;
    rd_en = 1'b0; rd_key_sel = '0; rd_round = '0; rd_decrypt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_key_ready", 48'(key_ready1), 48'd1);
    chk("rst_busy", 48'(busy1), 48'd0);
    chk("rst_keys_rdy", 48'(keys_rdy1), 48'd0);
    chk("rst_rd_data", rd_data1, 48'd0);
    chk("rst_parity", 48'(parity_err1), 48'd0);
    chk("rst_key_ready3", 48'(key_ready3), 48'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // DES load and full encrypt/decrypt sweeps
    load1(KEY_A);
    wait_rdy("des_rdy_edge", 1'b0, 18, 1'b0);
    chk("des_key_ready_with_rdy", 48'(key_ready1), 48'd1);
    for (int i = 0; i < 16; i++)
      rd($sformatf("enc_r%0d", i), 1'b0, 2'd0, 4'(i), 1'b0, K[i]);
    for (int i = 0; i < 16; i++)
      rd($sformatf("dec_r%0d", i), 1'b0, 2'd0, 4'(i), 1'b1, K[15-i]);
    rd("des_sel1_zero", 1'b0, 2'd1, 4'd0, 1'b0, 48'd0);
    rd("enc_r0_again", 1'b0, 2'd0, 4'd0, 1'b0, K[0]);
    rd_off();
    rd_round = 4'd9;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_no_rd_en", rd_data1, K[0]);

    // Reload: reads while busy return zero, keys_rdy timing unaffected
    load1(KEY_A);
    chk("reload_clears_rdy", 48'(keys_rdy1), 48'd0);
    for (int i = 0; i < 3; i++)
      rd($sformatf("busy_rd%0d", i), 1'b0, 2'd0, 4'd0, 1'b0, 48'd0);
    rd_off();
    wait_rdy("reload_rdy_edge", 1'b0, 15, 1'b0);
    rd("reload_r15", 1'b0, 2'd0, 4'd15, 1'b0, K[15]);
    rd_off();

    // 3DES with ignored key_valid pulses while busy
    @(negedge clk);
    key_in3 = {KEY_A, KEY_B, KEY_A}; key_valid3 = 1'b1;
    @(posedge clk); #1;
    key_valid3 = 1'b0;
    wait_rdy("3des_rdy_edge", 1'b1, 52, 1'b1);
    chk("3des_busy_done", 48'(busy3), 48'd0);
    rd("3des_s0_r0", 1'b1, 2'd0, 4'd0, 1'b0, K[0]);
    rd("3des_s2_r0", 1'b1, 2'd2, 4'd0, 1'b0, K[0]);
    rd("3des_s2_r15", 1'b1, 2'd2, 4'd15, 1'b0, K[15]);
    rd("3des_s0_r7", 1'b1, 2'd0, 4'd7, 1'b0, K[7]);
    rd("3des_s2_dec_r3", 1'b1, 2'd2, 4'd3, 1'b1, K[12]);
    rd("3des_s3_zero", 1'b1, 2'd3, 4'd0, 1'b0, 48'd0);
    rd_off();

    // Reset in the middle of GEN (r=7)
    load1(KEY_A);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_key_ready", 48'(key_ready1), 48'd1);
    chk("midrst_busy", 48'(busy1), 48'd0);
    chk("midrst_keys_rdy", 48'(keys_rdy1), 48'd0);
    chk("midrst_keys_rdy3", 48'(keys_rdy3), 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("postrst_r0", 1'b0, 2'd0, 4'd0, 1'b0, 48'd0);
    rd("postrst_r15", 1'b0, 2'd0, 4'd15, 1'b0, 48'd0);
    rd("postrst_3des_s2", 1'b1, 2'd2, 4'd0, 1'b0, 48'd0);
    rd_off();
    load1(KEY_A);
    wait_rdy("postrst_rdy_edge", 1'b0, 18, 1'b0);
    rd("postrst_reload_r0", 1'b0, 2'd0, 4'd0, 1'b0, K[0]);
    rd("postrst_reload_r15", 1'b0, 2'd0, 4'd15, 1'b0, K[15]);
    rd_off();

    // Bad-parity key: generation is unaffected
    load1(KEY_A ^ 64'd1);
`ifdef DES_KEY_SCHED_PARITY_CHK_EN
    chk("parity_err_set", 48'(parity_err1), 48'd1);
`else
    chk("parity_err_tied", 48'(parity_err1), 48'd0);
`endif
    wait_rdy("parity_rdy_edge", 1'b0, 18, 1'b0);
    rd("parity_key_r0", 1'b0, 2'd0, 4'd0, 1'b0, K[0]);
    rd_off();
    load1(KEY_A);
    chk("parity_err_clear", 48'(parity_err1), 48'd0);
    wait_rdy("parity_reload_rdy", 1'b0, 18, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
